// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the mux output pipeline stage: state encoding and default widths.
package mux_pipe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

  localparam int DW_DEF = 2;
  localparam int CW_DEF = 16;

endpackage

// File: rtl/mux_out_pipe.sv
// Registered valid/ready stage behind the 2:1 select mux, with one skid entry.
// Optional saturating stall counter enabled by defining MUX_PIPE_STALL_CNT_EN.
module mux_out_pipe
  import mux_pipe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
`ifdef MUX_PIPE_STALL_CNT_EN
  , output logic [CW-1:0] stall_cnt
`endif
);

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          acc_in_s;
  logic          acc_out_s;

  // Outputs decode from registers only, so no input reaches an output combinationally.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign out_data  = main_q;

  assign acc_in_s  = in_valid && in_ready;
  assign acc_out_s = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc_in_s) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (acc_in_s && acc_out_s) begin
          main_d = in_data;
        end else if (acc_in_s) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (acc_out_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        // Skid always drains behind main to keep ordering.
        if (acc_out_s) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= {DW{1'b0}};
      skid_q  <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef MUX_PIPE_STALL_CNT_EN
  logic [CW-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= {CW{1'b0}};
    end else if (out_valid && !out_ready && (stall_q != {CW{1'b1}})) begin
      stall_q <= stall_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cnt = stall_q;
`else
  logic unused_cw;
  assign unused_cw = (CW != 0);
`endif

endmodule

// File: tb/tb_mux_out_pipe.sv
// Directed self-checking bench for mux_out_pipe; stall counter steps run when MUX_PIPE_STALL_CNT_EN is defined.
module tb_mux_out_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_ready;
`ifdef MUX_PIPE_STALL_CNT_EN
  logic [2:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux_out_pipe #(.DW(2), .CW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef MUX_PIPE_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] d, input logic r);
    chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, v});
    chk({tag, ".out_data"},  {14'd0, out_data},  {14'd0, d});
    chk({tag, ".in_ready"},  {15'd0, in_ready},  {15'd0, r});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 2'b00;
    out_ready = 1'b0;
    #1;
    chk_out("reset", 1'b0, 2'b00, 1'b1);
    #11;
    rst = 1'b0;
    step();

    // 1: streaming with consumer always ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 2'd0; step(); chk_out("stream0", 1'b1, 2'd0, 1'b1);
    in_data   = 2'd1; step(); chk_out("stream1", 1'b1, 2'd1, 1'b1);
    in_data   = 2'd2; step(); chk_out("stream2", 1'b1, 2'd2, 1'b1);
    in_data   = 2'd3; step(); chk_out("stream3", 1'b1, 2'd3, 1'b1);
    // 5: drain keeps last data
    in_valid  = 1'b0; step(); chk_out("drain", 1'b0, 2'd3, 1'b1);

    // 2: backpressure fills skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 2'b01; step(); chk_out("bp_one", 1'b1, 2'b01, 1'b1);
    in_data   = 2'b10; step(); chk_out("bp_full", 1'b1, 2'b01, 1'b0);
    in_valid  = 1'b0;  step(); chk_out("bp_hold", 1'b1, 2'b01, 1'b0);
    out_ready = 1'b1;  step(); chk_out("bp_drain1", 1'b1, 2'b10, 1'b1);
    step(); chk_out("bp_drain2", 1'b0, 2'b10, 1'b1);

    // 3: simultaneous accept in and out while ONE
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 2'b11; step(); chk_out("sim_main", 1'b1, 2'b11, 1'b1);
    in_data   = 2'b00;
    out_ready = 1'b1;  step(); chk_out("sim_pass", 1'b1, 2'b00, 1'b1);
    in_valid  = 1'b0;  step(); chk_out("sim_empty", 1'b0, 2'b00, 1'b1);

    // 4: async reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 2'b01; step();
    in_data   = 2'b10; step(); chk_out("pre_rst_full", 1'b1, 2'b01, 1'b0);
    in_valid  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 2'b00, 1'b1);
    #2;
    rst = 1'b0;
    step(); chk_out("post_rst_idle", 1'b0, 2'b00, 1'b1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 2'b10; step(); chk_out("post_rst_send", 1'b1, 2'b10, 1'b1);
    in_valid  = 1'b0;  step(); chk_out("post_rst_only", 1'b0, 2'b10, 1'b1);

`ifdef MUX_PIPE_STALL_CNT_EN
    // 6: saturating stall counter, CW=3
    rst = 1'b1;
    #1;
    chk("stall_rst", {13'd0, stall_cnt}, 16'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 2'b01; step();
    in_valid  = 1'b0;
    chk("stall_start", {13'd0, stall_cnt}, 16'd0);
    for (int i = 0; i < 5; i++) step();
    chk("stall_5", {13'd0, stall_cnt}, 16'd5);
    for (int i = 0; i < 5; i++) step();
    chk("stall_sat", {13'd0, stall_cnt}, 16'd7);
    chk_out("stall_hold", 1'b1, 2'b01, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
